// File: rtl/dout_uart_tx_pkg.sv
// -----------------------------------------------------------------------------
// dout_uart_pkg
// Shared types and default constants for the debug-byte UART transmitter.
//   tx_state_t            : transmit FSM state encoding
//   DEFAULT_CLKS_PER_BIT  : default clock cycles per UART bit period
//   DEFAULT_FIFO_DEPTH    : default number of queued bytes
// -----------------------------------------------------------------------------
package dout_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int DEFAULT_CLKS_PER_BIT = 16;
    localparam int DEFAULT_FIFO_DEPTH   = 4;

endpackage

// File: rtl/dout_uart_tx_if.sv
// -----------------------------------------------------------------------------
// dout_uart_tx_if
// Bundles the processor debug byte and the UART-side outputs.
//   data_i     : processor debug byte (processor -> transmitter)
//   tx_o       : UART serial line, idles high
//   busy_o     : frame in flight or bytes queued
//   overflow_o : sticky, a byte was dropped on a full queue
// master = processor/board side, slave = transmitter.
// -----------------------------------------------------------------------------
interface dout_uart_tx_if;
    logic [7:0] data_i;
    logic       tx_o;
    logic       busy_o;
    logic       overflow_o;

    modport master (output data_i, input tx_o, input busy_o, input overflow_o);
    modport slave  (input data_i, output tx_o, output busy_o, output overflow_o);
endinterface

// File: rtl/dout_uart_tx_byte_fifo.sv
// -----------------------------------------------------------------------------
// byte_fifo
// Synchronous byte FIFO with combinational read data (head of queue).
//   clk_i/rst_i : clock, asynchronous active-high reset
//   push/din    : write request and data; accepted when not full, or when a
//                 pop happens on the same edge
//   pop/dout    : read request; dout always shows the oldest entry
//   full/empty  : occupancy flags
//   count       : entries held, 0..DEPTH
// -----------------------------------------------------------------------------
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push,
    input  logic                   pop,
    input  logic [7:0]             din,
    output logic [7:0]             dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    // A pop frees a slot in the same edge, so a full FIFO can still take a push.
    assign w_do_pop  = pop && (r_count != {CW{1'b0}});
    assign w_do_push = push && ((r_count != FULL_COUNT) || w_do_pop);

    assign dout  = r_mem[r_rd_ptr];
    assign full  = (r_count == FULL_COUNT);
    assign empty = (r_count == {CW{1'b0}});
    assign count = r_count;

    // Storage write; contents need no reset because count gates every read.
    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/dout_uart_tx.sv
// -----------------------------------------------------------------------------
// dout_uart_tx
// Watches the processor debug byte and sends every new value out as an 8N1
// UART frame. Changes are queued in a small FIFO; values arriving on a full
// queue are dropped and flagged. At board level data_i is wired to the
// processor data_out_o and tx_o to the UART pin.
//   clk_i      : sole clock
//   rst_i      : asynchronous active-high reset (aborts any frame)
//   bus.data_i : debug byte, sampled every cycle
//   bus.tx_o   : serial line, idles high
//   bus.busy_o : frame in flight or FIFO non-empty
//   bus.overflow_o : sticky drop flag
// -----------------------------------------------------------------------------
module dout_uart_tx
    import dout_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
    input  logic           clk_i,
    input  logic           rst_i,
    dout_uart_tx_if.slave  bus
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0] BAUD_LOAD = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
    localparam logic [BW-1:0] BAUD_ZERO = BW'(0);

    tx_state_t     r_state;
    tx_state_t     w_state_nxt;
    logic [BW-1:0] r_baud;
    logic [BW-1:0] w_baud_nxt;
    logic [2:0]    r_bit_idx;
    logic [2:0]    w_bit_idx_nxt;
    logic [7:0]    r_shift;
    logic [7:0]    w_shift_nxt;
    logic          r_tx;
    logic          w_tx_nxt;
    logic [7:0]    r_prev_q;
    logic          r_overflow;

    logic          w_push;
    logic          w_pop;
    logic [7:0]    w_fifo_dout;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;

    assign w_push = (bus.data_i != r_prev_q);

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (w_push),
        .pop   (w_pop),
        .din   (bus.data_i),
        .dout  (w_fifo_dout),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    // Change detector and sticky drop flag; prev_q follows data_i even when the byte is dropped.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_prev_q   <= 8'h00;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_prev_q <= bus.data_i;
            end
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Transmit FSM state and datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_baud    <= BAUD_ZERO;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_baud    <= w_baud_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_tx      <= w_tx_nxt;
        end
    end

    // Next-state logic; the shift register moves right so bit 0 is always the next data bit.
    always_comb begin
        w_state_nxt   = r_state;
        w_baud_nxt    = r_baud;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_tx_nxt      = r_tx;
        w_pop         = 1'b0;
        case (r_state)
            IDLE: begin
                w_tx_nxt = 1'b1;
                if (!w_empty) begin
                    w_pop         = 1'b1;
                    w_shift_nxt   = w_fifo_dout;
                    w_baud_nxt    = BAUD_LOAD;
                    w_bit_idx_nxt = 3'd0;
                    w_tx_nxt      = 1'b0;
                    w_state_nxt   = START;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            START: begin
                if (r_baud == BAUD_ZERO) begin
                    w_state_nxt   = DATA;
                    w_baud_nxt    = BAUD_LOAD;
                    w_bit_idx_nxt = 3'd0;
                    w_tx_nxt      = r_shift[0];
                    w_shift_nxt   = {1'b0, r_shift[7:1]};
                end else begin
                    w_baud_nxt = r_baud - BAUD_ONE;
                end
            end
            DATA: begin
                if (r_baud == BAUD_ZERO) begin
                    w_baud_nxt = BAUD_LOAD;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                        w_tx_nxt      = r_shift[0];
                        w_shift_nxt   = {1'b0, r_shift[7:1]};
                    end
                end else begin
                    w_baud_nxt = r_baud - BAUD_ONE;
                end
            end
            STOP: begin
                w_tx_nxt = 1'b1;
                if (r_baud == BAUD_ZERO) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_baud_nxt = r_baud - BAUD_ONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

    assign bus.tx_o       = r_tx;
    assign bus.busy_o     = (r_state != IDLE) || (w_count != {CW{1'b0}});
    assign bus.overflow_o = r_overflow;

endmodule

// File: tb/tb_dout_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_dout_uart_tx
// Self-checking bench: a queue-based behavioural model predicts tx/busy/overflow
// every cycle, a software UART receiver decodes frames, and directed scenarios
// add literal expectations; a randomized phase closes the run.
// -----------------------------------------------------------------------------
module tb_dout_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;

    dout_uart_tx_if ifc ();

    dout_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (ifc)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        n_checks++;
        if (act_v !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act_v, exp_v, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] m_q[$];
    logic [7:0] m_prev = 8'h00;
    bit         m_act  = 1'b0;
    int         m_cnt  = 0;
    logic [7:0] m_byte = 8'h00;
    bit         m_ovf  = 1'b0;

    // Line value: cycle m_cnt of a frame falls in bit slot m_cnt/CPB of {start, d0..d7, stop}.
    function automatic logic m_tx();
        int k;
        if (!m_act) return 1'b1;
        k = m_cnt / CPB;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return m_byte[k-1];
    endfunction

    initial forever begin
        @(posedge clk_i or posedge rst_i);
        begin : model_step
            int pre;
            bit popped;
            if (rst_i) begin
                m_q.delete();
                m_prev = 8'h00;
                m_act  = 1'b0;
                m_cnt  = 0;
                m_ovf  = 1'b0;
            end else begin
                pre    = m_q.size();
                popped = 1'b0;
                if (m_act) begin
                    m_cnt++;
                    if (m_cnt == FRAME) m_act = 1'b0;
                end else if (pre != 0) begin
                    m_byte = m_q.pop_front();
                    m_act  = 1'b1;
                    m_cnt  = 0;
                    popped = 1'b1;
                end
                if (ifc.data_i != m_prev) begin
                    if ((pre < DEPTH) || popped) m_q.push_back(ifc.data_i);
                    else m_ovf = 1'b1;
                    m_prev = ifc.data_i;
                end
            end
            if (clk_i) cyc++;
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk_i);
        check("tx_o", {31'd0, ifc.tx_o}, {31'd0, m_tx()});
        check("busy_o", {31'd0, ifc.busy_o}, {31'd0, (m_act || (m_q.size() != 0))});
        check("overflow_o", {31'd0, ifc.overflow_o}, {31'd0, m_ovf});
    end

    // ---------------- software UART receiver ----------------
    logic [7:0] rx_q[$];
    int         rx_t[$];
    bit         rx_on = 1'b0;
    int         rx_n  = 0;
    logic [7:0] rx_sh = 8'h00;

    initial forever begin
        @(negedge clk_i);
        begin : rx_step
            int k;
            if (rst_i) begin
                rx_on = 1'b0;
            end else if (!rx_on) begin
                if (ifc.tx_o === 1'b0) begin
                    rx_on = 1'b1;
                    rx_n  = 0;
                    rx_t.push_back(cyc);
                end
            end else begin
                rx_n++;
                if ((rx_n % CPB) == (CPB / 2)) begin
                    k = rx_n / CPB;
                    if (k >= 1 && k <= 8) begin
                        rx_sh[k-1] = ifc.tx_o;
                    end else if (k == 9) begin
                        check("rx_stop_bit", {31'd0, ifc.tx_o}, 32'd1);
                        rx_q.push_back(rx_sh);
                        rx_on = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk_i);
        #1;
        rst_i      = 1'b1;
        ifc.data_i = 8'h00;
        step(2);
        rst_i = 1'b0;
        rx_q.delete();
        rx_t.delete();
    endtask

    task automatic wait_idle(input int budget);
        int i;
        i = 0;
        while ((ifc.busy_o !== 1'b0) && (i < budget)) begin
            step(1);
            i++;
        end
        check("idle_within_budget", {31'd0, (i < budget)}, 32'd1);
        step(2);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        int exp_bits[10];
        exp_bits = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
        ifc.data_i = 8'h00;
        #1 rst_i = 1'b1;
        step(2);
        rst_i = 1'b0;

        // Reset state
        check("reset_tx", {31'd0, ifc.tx_o}, 32'd1);
        check("reset_busy", {31'd0, ifc.busy_o}, 32'd0);
        check("reset_ovf", {31'd0, ifc.overflow_o}, 32'd0);

        // Single byte A5: push on edge 1, launch on edge 2, then the frame bits
        do_reset();
        ifc.data_i = 8'hA5;
        step(1);
        check("lat_edge1_tx", {31'd0, ifc.tx_o}, 32'd1);
        check("lat_edge1_busy", {31'd0, ifc.busy_o}, 32'd1);
        step(1);
        check("lat_edge2_tx", {31'd0, ifc.tx_o}, 32'd0);
        for (int k = 0; k < 10; k++) begin
            step((k == 0) ? 2 : 4);
            check("a5_line_bit", {31'd0, ifc.tx_o}, exp_bits[k]);
            check("a5_model_bit", {31'd0, m_tx()}, exp_bits[k]);
        end
        step(1);
        check("a5_busy_in_stop", {31'd0, ifc.busy_o}, 32'd1);
        step(2);
        check("a5_busy_low_41", {31'd0, ifc.busy_o}, 32'd0);
        step(2);
        check("a5_rx_count", rx_q.size(), 32'd1);
        if (rx_q.size() > 0) check("a5_rx_byte", {24'd0, rx_q[0]}, 32'hA5);

        // No change: 0x00 held after reset is never sent
        do_reset();
        for (int i = 0; i < 100; i++) begin
            step(1);
            check("hold00_tx", {31'd0, ifc.tx_o}, 32'd1);
            check("hold00_busy", {31'd0, ifc.busy_o}, 32'd0);
        end

        // Burst 01..06: 01 launches, 02..05 queued, 06 dropped
        do_reset();
        for (int v = 1; v <= 6; v++) begin
            ifc.data_i = 8'(v);
            step(1);
        end
        check("burst_overflow", {31'd0, ifc.overflow_o}, 32'd1);
        wait_idle(400);
        check("burst_rx_count", rx_q.size(), 32'd5);
        for (int i = 0; i < rx_q.size(); i++) begin
            check("burst_rx_byte", {24'd0, rx_q[i]}, i + 1);
            if (i > 0 && i < rx_t.size()) check("burst_spacing", rx_t[i] - rx_t[i-1], FRAME + 1);
        end

        // Full FIFO plus pop on the same edge: the new byte is kept
        do_reset();
        for (int v = 8'h10; v <= 8'h14; v++) begin
            ifc.data_i = 8'(v);
            step(1);
        end
        step(37);
        ifc.data_i = 8'h15;
        step(1);
        check("fullpop_no_ovf", {31'd0, ifc.overflow_o}, 32'd0);
        wait_idle(500);
        check("fullpop_rx_count", rx_q.size(), 32'd6);
        if (rx_q.size() > 0) check("fullpop_last", {24'd0, rx_q[rx_q.size()-1]}, 32'h15);
        check("fullpop_ovf_end", {31'd0, ifc.overflow_o}, 32'd0);

        // Reset during data bit 3 aborts the frame at once
        do_reset();
        ifc.data_i = 8'h5A;
        step(2);
        step(17);
        check("midframe_busy_before", {31'd0, ifc.busy_o}, 32'd1);
        rst_i      = 1'b1;
        ifc.data_i = 8'h00;
        #1;
        check("rst_async_tx", {31'd0, ifc.tx_o}, 32'd1);
        check("rst_async_busy", {31'd0, ifc.busy_o}, 32'd0);
        step(2);
        rst_i = 1'b0;
        rx_q.delete();
        rx_t.delete();
        step(60);
        check("after_rst_no_frames", rx_q.size(), 32'd0);
        check("after_rst_busy", {31'd0, ifc.busy_o}, 32'd0);
        ifc.data_i = 8'h7E;
        step(1);
        wait_idle(200);
        check("after_rst_rx_count", rx_q.size(), 32'd1);
        if (rx_q.size() > 0) check("after_rst_rx_byte", {24'd0, rx_q[0]}, 32'h7E);

        // Repeated value is sent once
        do_reset();
        ifc.data_i = 8'h33;
        step(50);
        ifc.data_i = 8'h33;
        step(1);
        ifc.data_i = 8'h34;
        step(1);
        wait_idle(300);
        check("repeat_rx_count", rx_q.size(), 32'd2);
        if (rx_q.size() == 2) begin
            check("repeat_rx0", {24'd0, rx_q[0]}, 32'h33);
            check("repeat_rx1", {24'd0, rx_q[1]}, 32'h34);
        end

        // Randomized traffic with occasional resets, checked cycle by cycle
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) ifc.data_i = 8'($urandom);
            if ($urandom_range(0, 499) == 0) begin
                rst_i = 1'b1;
                step(1);
                rst_i = 1'b0;
            end else begin
                step(1);
            end
        end
        wait_idle(1000);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/dout_uart_tx.md
DOUT_UART_TX -- requirements
Module: dout_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clock cycles per UART bit period; legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 4: byte FIFO entries; power of two, at least 2.
REQ-003 Clock is clk_i and reset is rst_i; there is one clock, and reset is asynchronous and active-high.
REQ-004 clk_i  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_i  input  1  asynchronous active-high reset.
REQ-006 data_i  input  8  processor debug byte (a0[7:0]), sampled every cycle.
REQ-007 tx_o  output  1  UART serial line; idles high.
REQ-008 busy_o  output  1  high while a frame is in flight or the FIFO is non-empty.
REQ-009 overflow_o  output  1  sticky flag; a byte was dropped because the FIFO was full.

Function
REQ-010 A register prev_q shall hold the last accepted data_i value.
REQ-011 On each rising edge where data_i != prev_q, the block shall set prev_q <= data_i and push data_i into the FIFO.
REQ-012 When data_i == prev_q, nothing shall be pushed.
REQ-013 The transmit FSM shall have the states IDLE, START, DATA and STOP.
REQ-014 In IDLE with the FIFO non-empty, the FSM shall pop one byte into an 8-bit shift register on the next edge, enter START and drive tx_o low.
REQ-015 START shall last CLKS_PER_BIT cycles with tx_o=0, then the FSM enters DATA.
REQ-016 DATA shall send 8 bits LSB first, each held CLKS_PER_BIT cycles, counted by a 3-bit bit index; after bit 7 the FSM enters STOP.
REQ-017 STOP shall hold tx_o=1 for CLKS_PER_BIT cycles, then the FSM enters IDLE.
REQ-018 The FSM shall stay in IDLE for at least 1 cycle between frames.
REQ-019 The baud counter shall load CLKS_PER_BIT-1 on each state or bit entry and count down to 0; its width is $clog2(CLKS_PER_BIT).
REQ-020 Latency: tx_o shall fall exactly 2 edges after data_i first differs from prev_q, provided the FSM is IDLE and the FIFO is empty (edge 1 pushes, edge 2 launches).
REQ-021 A frame shall occupy 10*CLKS_PER_BIT cycles; back-to-back frames start (10*CLKS_PER_BIT)+1 cycles apart.
REQ-022 Full FIFO with a push and no pop on the same edge: the byte shall be dropped, overflow_o shall be set, and prev_q shall still update.
REQ-023 Full FIFO with a push and a pop on the same edge: the push shall be accepted and overflow_o shall not be set.
REQ-024 Empty FIFO: no pop shall occur and the FSM shall remain in IDLE with tx_o=1.
REQ-025 FIFO pointers shall wrap modulo FIFO_DEPTH; the count shall range 0..FIFO_DEPTH using $clog2(FIFO_DEPTH)+1 bits.
REQ-026 busy_o shall be the combinational expression (state != IDLE) || (count != 0).
REQ-027 overflow_o shall stay set until reset.

Reset
REQ-028 When rst_i asserts, the block shall immediately, without waiting for a clock edge, set tx_o=1, state=IDLE, overflow_o=0, FIFO count and pointers to 0, prev_q=8'h00, baud counter and bit index to 0.
REQ-029 Reset mid-frame shall abort the frame (the line goes high at once) and discard all queued bytes.
REQ-030 After reset, data_i=8'h00 shall not be transmitted until it changes.

Structure
REQ-031 Package dout_uart_pkg shall hold the FSM state enum (tx_state_t: IDLE, START, DATA, STOP) and the default constants DEFAULT_CLKS_PER_BIT=16 and DEFAULT_FIFO_DEPTH=4.
REQ-032 The block shall instantiate one sub-module, byte_fifo (synchronous FIFO, parameter DEPTH, ports push/pop/din/dout/full/empty/count), on clk_i/rst_i.
REQ-033 The top-level integration shall connect data_i to the processor data_out_o and tx_o to the board pin.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-034 Single byte: reset, then data_i=8'hA5 -> tx_o falls 2 edges later, then line bits 0,1,0,1,0,0,1,0,1,1 each held 4 cycles, busy_o low 41 cycles after the fall.
REQ-035 No change: hold data_i=8'h00 for 100 cycles after reset -> tx_o stays 1 and busy_o stays 0 throughout.
REQ-036 Burst: data_i 8'h01,8'h02,8'h03,8'h04,8'h05,8'h06 on consecutive cycles -> the first byte launches immediately, 4 are queued, 8'h06 is dropped, overflow_o=1, and frames 01,02,03,04,05 are transmitted 41 cycles apart.
REQ-037 Full plus pop: with the FIFO full, present a new byte on the edge where IDLE pops -> the byte is accepted, overflow_o=0, and it is the last frame sent.
REQ-038 Reset mid-frame: assert rst_i during DATA bit 3 -> tx_o=1 at once, busy_o=0, and after release there are no frames until data_i changes.
REQ-039 Repeat value: 8'h33, then 8'h33 again 50 cycles later, then 8'h34 -> exactly two frames are sent (33h, then 34h).
